// File: rtl/oled_layer_arbiter_pkg.sv
// Shared widths, FSM encoding and window type for the OLED layer arbiter.
// A window with x0>x1 or y0>y1 can never produce a hit.
package oled_layer_arbiter_pkg;
   localparam int ROW_W = 6;
   localparam int COL_W = 7;
   localparam int RGB_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_FG = 2'd1,
      ST_WAIT_BG = 2'd2,
      ST_RESP    = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic [COL_W-1:0] x0;
      logic [COL_W-1:0] x1;
      logic [ROW_W-1:0] y0;
      logic [ROW_W-1:0] y1;
   } win_t;

   localparam win_t WIN_EMPTY = '{x0: 7'd127, x1: 7'd0, y0: 6'd63, y1: 6'd0};
endpackage

// File: rtl/oled_layer_arbiter_window_hit.sv
// Inclusive rectangle test: pixel (row, col) against window bounds.
module oled_layer_arbiter_window_hit
   import oled_layer_arbiter_pkg::*;
(
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   input  win_t             win,
   output logic             hit
);
   assign hit = (col >= win.x0) && (col <= win.x1) &&
                (row >= win.y0) && (row <= win.y1);
endmodule

// File: rtl/oled_layer_arbiter.sv
// Routes OLED pixel reads to fg (inside window, unless colour-keyed) or bg,
// with a tear-free window commit at pixel (0,0) and a per-request timeout.
module oled_layer_arbiter
   import oled_layer_arbiter_pkg::*;
#(
   parameter int unsigned      TIMEOUT     = 15,
   parameter logic [RGB_W-1:0] KEY_RGB     = 16'hF81F,
   parameter logic [RGB_W-1:0] DEFAULT_RGB = 16'h0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             read,
   input  logic [ROW_W-1:0] row_idx,
   input  logic [COL_W-1:0] column_idx,
   output logic [RGB_W-1:0] data_rgb,
   output logic             ack,
   output logic [ROW_W-1:0] src_row_idx,
   output logic [COL_W-1:0] src_column_idx,
   output logic             bg_read,
   input  logic [RGB_W-1:0] bg_data_rgb,
   input  logic             bg_ack,
   output logic             fg_read,
   input  logic [RGB_W-1:0] fg_data_rgb,
   input  logic             fg_ack,
   input  logic             cfg_we,
   input  logic [COL_W-1:0] win_x0,
   input  logic [COL_W-1:0] win_x1,
   input  logic [ROW_W-1:0] win_y0,
   input  logic [ROW_W-1:0] win_y1,
   output logic             timeout_err
);
   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

   arb_state_e       state, state_nxt;
   win_t             shadow, active, win_eff;
   logic             cfg_pend, commit, hit;
   logic [7:0]       cnt;
   logic             fg_read_nxt, bg_read_nxt, set_err;
   logic [RGB_W-1:0] data_nxt;

   // The frame-start read sees the freshly committed window, not the stale one.
   assign commit  = (state == ST_IDLE) && read && (row_idx == '0) && (column_idx == '0) && cfg_pend;
   assign win_eff = commit ? shadow : active;
   assign ack     = (state == ST_RESP);

   oled_layer_arbiter_window_hit u_hit (
      .row (row_idx),
      .col (column_idx),
      .win (win_eff),
      .hit (hit)
   );

   always_comb begin
      state_nxt   = state;
      fg_read_nxt = 1'b0;
      bg_read_nxt = 1'b0;
      set_err     = 1'b0;
      data_nxt    = data_rgb;
      unique case (state)
         ST_IDLE: if (read) begin
            if (hit) begin
               state_nxt   = ST_WAIT_FG;
               fg_read_nxt = 1'b1;
            end else begin
               state_nxt   = ST_WAIT_BG;
               bg_read_nxt = 1'b1;
            end
         end
         ST_WAIT_FG: if (fg_ack) begin
            if (fg_data_rgb == KEY_RGB) begin
               state_nxt   = ST_WAIT_BG;
               bg_read_nxt = 1'b1;
            end else begin
               state_nxt = ST_RESP;
               data_nxt  = fg_data_rgb;
            end
         end else if (cnt == TO_CNT) begin
            state_nxt = ST_RESP;
            data_nxt  = DEFAULT_RGB;
            set_err   = 1'b1;
         end
         ST_WAIT_BG: if (bg_ack) begin
            state_nxt = ST_RESP;
            data_nxt  = bg_data_rgb;
         end else if (cnt == TO_CNT) begin
            state_nxt = ST_RESP;
            data_nxt  = DEFAULT_RGB;
            set_err   = 1'b1;
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         fg_read        <= 1'b0;
         bg_read        <= 1'b0;
         data_rgb       <= '0;
         src_row_idx    <= '0;
         src_column_idx <= '0;
         timeout_err    <= 1'b0;
         shadow         <= WIN_EMPTY;
         active         <= WIN_EMPTY;
         cfg_pend       <= 1'b0;
      end else begin
         state       <= state_nxt;
         // Every state change (including fg->bg on a key hit) restarts the wait.
         cnt         <= (state_nxt != state) ? '0 : cnt + 8'd1;
         fg_read     <= fg_read_nxt;
         bg_read     <= bg_read_nxt;
         data_rgb    <= data_nxt;
         timeout_err <= timeout_err | set_err;
         if (state == ST_IDLE && read) begin
            src_row_idx    <= row_idx;
            src_column_idx <= column_idx;
         end
         if (commit) active <= shadow;
         if (cfg_we) begin
            shadow   <= '{x0: win_x0, x1: win_x1, y0: win_y0, y1: win_y1};
            cfg_pend <= 1'b1;
         end else if (commit) begin
            cfg_pend <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_oled_layer_arbiter.sv
// Directed bench: a latency-level model predicts per-cycle outputs; literal checks pin key cases.
module tb_oled_layer_arbiter;
   localparam int          TO  = 15;
   localparam logic [15:0] KEY = 16'hF81F;
   localparam int          N   = 4096;

   logic        clk = 1'b0, reset = 1'b1, read = 1'b0, cfg_we = 1'b0;
   logic [5:0]  row_idx = '0, win_y0 = '0, win_y1 = '0;
   logic [6:0]  column_idx = '0, win_x0 = '0, win_x1 = '0;
   logic [15:0] data_rgb, bg_data_rgb, fg_data_rgb;
   logic        ack, bg_read, fg_read, bg_ack, fg_ack, timeout_err;
   logic [5:0]  src_row_idx;
   logic [6:0]  src_column_idx;

   oled_layer_arbiter #(.TIMEOUT(TO), .KEY_RGB(KEY), .DEFAULT_RGB(16'h0000)) dut (
      .clk(clk), .reset(reset), .read(read), .row_idx(row_idx), .column_idx(column_idx),
      .data_rgb(data_rgb), .ack(ack), .src_row_idx(src_row_idx), .src_column_idx(src_column_idx),
      .bg_read(bg_read), .bg_data_rgb(bg_data_rgb), .bg_ack(bg_ack),
      .fg_read(fg_read), .fg_data_rgb(fg_data_rgb), .fg_ack(fg_ack),
      .cfg_we(cfg_we), .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0, n_err = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Model: window registers, expected-output schedule indexed by cycle.
   int          m_sh[4], m_act[4];
   bit          m_pend;
   int          free_at = 0;
   bit          e_ack[N], e_fg[N], e_bg[N], e_err[N], e_src[N], e_rst[N];
   logic [15:0] e_data[N];
   logic [5:0]  e_row[N];
   logic [6:0]  e_col[N];

   // Source emulation: each source answers lat cycles after its read pulse.
   int          fg_lat = 1, bg_lat = 1, fg_at = -1, bg_at = -1, fg_stray_at = -1;
   logic [15:0] fg_val = '0, bg_val = '0;

   task automatic predict(input int t0, input int r, input int c);
      int t, resp;
      logic [15:0] d;
      bit err, hit, to_bg;
      if (t0 < free_at) return;
      if (r == 0 && c == 0 && m_pend) begin m_act = m_sh; m_pend = 0; end
      hit = (c >= m_act[0]) && (c <= m_act[1]) && (r >= m_act[2]) && (r <= m_act[3]);
      t = t0 + 1;
      e_src[t] = 1; e_row[t] = 6'(r); e_col[t] = 7'(c);
      err = 0; to_bg = !hit; d = '0; resp = t;
      if (hit) begin
         e_fg[t] = 1;
         if (fg_lat > TO) begin resp = t + TO + 1; err = 1; end
         else if (fg_val == KEY) begin t = t + fg_lat + 1; to_bg = 1; end
         else begin resp = t + fg_lat + 1; d = fg_val; end
      end
      if (to_bg) begin
         e_bg[t] = 1;
         if (bg_lat > TO) begin resp = t + TO + 1; err = 1; d = '0; end
         else begin resp = t + bg_lat + 1; d = bg_val; end
      end
      e_ack[resp] = 1; e_data[resp] = d;
      if (err) e_err[resp] = 1;
      free_at = resp + 1;
   endtask

   task automatic model_reset(input int t0);
      for (int i = t0 + 1; i < N; i++) begin
         e_ack[i] = 0; e_fg[i] = 0; e_bg[i] = 0; e_err[i] = 0; e_src[i] = 0;
      end
      e_rst[t0 + 1] = 1;
      m_act = '{127, 0, 63, 0}; m_sh = '{127, 0, 63, 0}; m_pend = 0;
      free_at = t0 + 1;
   endtask

   initial begin
      fg_ack = 0; bg_ack = 0; fg_data_rgb = '0; bg_data_rgb = '0;
      forever begin
         @(posedge clk); #1;
         fg_ack      = (cyc == fg_at) || (cyc == fg_stray_at);
         fg_data_rgb = (cyc == fg_at) ? fg_val : 16'hBAD0;
         bg_ack      = (cyc == bg_at);
         bg_data_rgb = (cyc == bg_at) ? bg_val : 16'hBAD1;
      end
   end

   always @(negedge clk) begin
      if (reset) begin fg_at = -1; bg_at = -1; end
      else begin
         if (fg_read) fg_at = cyc + fg_lat;
         if (bg_read) bg_at = cyc + bg_lat;
      end
   end

   // Per-cycle compare against the model schedule.
   bit          chk_on = 0;
   logic [15:0] h_data = '0;
   logic        h_err = 0;
   logic [5:0]  h_row = '0;
   logic [6:0]  h_col = '0;
   int          last_ack_cyc = -1, n_acks = 0;
   logic [15:0] last_ack_data = '0;
   always @(negedge clk) begin
      if (chk_on) begin
         if (e_rst[cyc]) begin h_data = '0; h_err = 0; h_row = '0; h_col = '0; end
         if (e_ack[cyc]) h_data = e_data[cyc];
         if (e_err[cyc]) h_err = 1;
         if (e_src[cyc]) begin h_row = e_row[cyc]; h_col = e_col[cyc]; end
         chk("ack", 32'(ack), 32'(e_ack[cyc]));
         chk("fg_read", 32'(fg_read), 32'(e_fg[cyc]));
         chk("bg_read", 32'(bg_read), 32'(e_bg[cyc]));
         chk("data_rgb", 32'(data_rgb), 32'(h_data));
         chk("timeout_err", 32'(timeout_err), 32'(h_err));
         chk("src_row", 32'(src_row_idx), 32'(h_row));
         chk("src_col", 32'(src_column_idx), 32'(h_col));
      end
      if (ack === 1'b1) begin last_ack_cyc = cyc; last_ack_data = data_rgb; n_acks++; end
   end

   task automatic drive(input bit rd, input int r, input int c, input bit we,
                        input int x0, input int x1, input int y0, input int y1, output int t0);
      @(posedge clk); #1;
      t0 = cyc;
      read = rd; row_idx = 6'(r); column_idx = 7'(c);
      cfg_we = we; win_x0 = 7'(x0); win_x1 = 7'(x1); win_y0 = 6'(y0); win_y1 = 6'(y1);
      if (rd) predict(t0, r, c);
      if (we) begin m_sh = '{x0, x1, y0, y1}; m_pend = 1; end
      @(posedge clk); #1;
      read = 0; cfg_we = 0;
   endtask

   task automatic cfg(input int x0, input int x1, input int y0, input int y1);
      int t;
      drive(0, 0, 0, 1, x0, x1, y0, y1, t);
   endtask

   // Read, wait (bounded) for its ack, then optionally pin latency and data literally.
   task automatic xact(input string nm, input int r, input int c, input bit lit,
                       input int want_lat, input logic [15:0] want_d);
      int t0, n;
      drive(1, r, c, 0, 0, 0, 0, 0, t0);
      n = 0;
      while (last_ack_cyc <= t0 && n < 60) begin @(posedge clk); n++; end
      if (last_ack_cyc <= t0) chk({nm, "_ack_seen"}, 0, 1);
      else if (lit) begin
         chk({nm, "_lat"}, 32'(last_ack_cyc - t0), 32'(want_lat));
         chk({nm, "_data"}, 32'(last_ack_data), 32'(want_d));
      end
      repeat (2) @(posedge clk);
   endtask

   int t5, acks0;
   int edge_tab[6][2] = '{'{0, 0}, '{4, 8}, '{7, 15}, '{3, 8}, '{4, 16}, '{8, 8}};

   initial begin
      m_act = '{127, 0, 63, 0}; m_sh = '{127, 0, 63, 0}; m_pend = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      chk_on = 1;
      e_rst[cyc] = 1;
      free_at = cyc;
      @(negedge clk);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_fg_read", 32'(fg_read), 0);
      chk("rst_bg_read", 32'(bg_read), 0);
      chk("rst_data", 32'(data_rgb), 0);
      chk("rst_src", 32'({src_row_idx, src_column_idx}), 0);
      chk("rst_err", 32'(timeout_err), 0);

      // 1: empty window -> bg
      bg_lat = 1; bg_val = 16'h1234;
      xact("t1", 10, 20, 1, 3, 16'h1234);

      // 2: shadow written mid-frame is not used until (0,0)
      cfg(8, 15, 4, 7);
      bg_val = 16'hAAAA; fg_val = 16'h07E0; fg_lat = 1;
      xact("t2_pre", 5, 10, 1, 3, 16'hAAAA);
      xact("t2_commit", 0, 0, 1, 3, 16'hAAAA);
      xact("t2_fg", 5, 10, 1, 3, 16'h07E0);

      // 3: transparent fg falls through to bg
      fg_val = KEY; bg_val = 16'h001F;
      xact("t3", 6, 12, 1, 5, 16'h001F);

      // 4: bg hangs -> default pixel and sticky error; late ack ignored
      bg_lat = 20;
      xact("t4", 1, 1, 1, TO + 2, 16'h0000);
      chk("t4_err", 32'(timeout_err), 1);
      repeat (10) @(posedge clk);
      bg_lat = 1; bg_val = 16'h5555;
      xact("t4_next", 1, 1, 1, 3, 16'h5555);
      chk("t4_err_sticky", 32'(timeout_err), 1);

      // 5: extra read and stray fg_ack while waiting on bg
      bg_lat = 4; bg_val = 16'h0BEE;
      acks0 = n_acks;
      drive(1, 2, 2, 0, 0, 0, 0, 0, t5);
      fg_stray_at = t5 + 3;
      drive(1, 9, 9, 0, 0, 0, 0, 0, acks0);
      acks0 = n_acks;
      repeat (12) @(posedge clk);
      chk("t5_one_ack", 32'(n_acks - acks0), 1);
      chk("t5_data", 32'(last_ack_data), 32'(16'h0BEE));
      chk("t5_lat", 32'(last_ack_cyc - t5), 6);
      fg_stray_at = -1;

      // 6: reset during WAIT_FG; pending config discarded
      cfg(0, 95, 0, 63);
      fg_lat = 1000; fg_val = 16'h0ABC;
      drive(1, 5, 10, 0, 0, 0, 0, 0, t5);
      acks0 = n_acks;
      @(posedge clk); #1;
      reset = 1;
      model_reset(cyc);
      @(posedge clk); #1;
      reset = 0;
      repeat (20) @(posedge clk);
      chk("t6_no_ack", 32'(n_acks - acks0), 0);
      bg_lat = 1; bg_val = 16'h7777; fg_lat = 1;
      xact("t6_origin", 0, 0, 1, 3, 16'h7777);
      xact("t6_after", 5, 10, 1, 3, 16'h7777);
      chk("t6_err_clr", 32'(timeout_err), 0);

      // Window edges (inclusive bounds)
      cfg(8, 15, 4, 7);
      bg_lat = 2; bg_val = 16'h1111; fg_val = 16'h2222;
      foreach (edge_tab[i]) xact("edge", edge_tab[i][0], edge_tab[i][1], 0, 0, '0);

      // cfg_we on the commit cycle: old shadow committed, new one stays pending
      cfg(20, 30, 0, 63);
      drive(1, 0, 0, 1, 40, 50, 10, 20, t5);
      repeat (8) @(posedge clk);
      xact("sc_hit_old", 5, 25, 1, 3, 16'h2222);
      xact("sc_commit2", 0, 0, 0, 0, '0);
      xact("sc_hit_new", 15, 45, 1, 3, 16'h2222);
      xact("sc_miss", 5, 25, 1, 4, 16'h1111);

      // Timeout boundary on fg: ack exactly at TIMEOUT wins
      fg_lat = TO; fg_val = 16'h0ABC;
      xact("to_edge", 15, 45, 1, TO + 2, 16'h0ABC);
      chk("to_edge_err", 32'(timeout_err), 0);
      fg_lat = TO + 1;
      xact("to_over", 15, 45, 1, TO + 2, 16'h0000);
      chk("to_over_err", 32'(timeout_err), 1);
      repeat (20) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end
endmodule
